// File: rtl/trng_pool.sv
// Entropy pool: parity post-filter, word assembly and a small FIFO of random words.
// Define TRNG_POOL_HEALTH_EN to compile in the repetition-count health test and alarm.
module trng_pool #(
  parameter int W     = 32,
  parameter int ORD   = 3,
  parameter int DEPTH = 4,
  parameter int RCT_C = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     src_en,
  input  logic                     src_val,
  input  logic                     src_bit,
  input  logic                     rd_req,
  output logic                     rd_val,
  output logic [W-1:0]             rdn,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     alarm,
  input  logic                     alarm_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = $clog2(ORD);
  localparam int CW = $clog2(W);

  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          filt_acc_q, filt_acc_d;
  logic          filt_val_q, filt_val_d;
  logic          filt_bit_q, filt_bit_d;
  logic [W-1:0]  asm_q, asm_d;
  logic [CW-1:0] asm_cnt_q, asm_cnt_d;
  logic          pend_q, pend_d;
  logic [W-1:0]  pend_word_q, pend_word_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          src_en_q, src_en_d;
  logic          alarm_q, alarm_d;
  logic          accept, push, pop, flush;
  logic [W-1:0]  mem [DEPTH];

`ifdef TRNG_POOL_HEALTH_EN
  logic [7:0]    run_q, run_d;
  logic          last_q, last_d;
`else
  logic          unused_alarm_clr;
  assign unused_alarm_clr = alarm_clr;
`endif

  assign accept = src_val && src_en_q;
  assign rd_val = (level_q != '0) && !alarm_q;
  assign pop    = rd_req && rd_val;
  // A finished word waits in pend_q until the buffer has room.
  assign push   = pend_q && (level_q != LW'(DEPTH));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    filt_cnt_d  = filt_cnt_q;
    filt_acc_d  = filt_acc_q;
    filt_val_d  = 1'b0;
    filt_bit_d  = filt_bit_q;
    asm_d       = asm_q;
    asm_cnt_d   = asm_cnt_q;
    pend_d      = pend_q && !push;
    pend_word_d = pend_word_q;
    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d     = level_q;
    alarm_d     = alarm_q;
    flush       = 1'b0;

    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);

    if (accept) begin
      if (filt_cnt_q == FW'(ORD - 1)) begin
        filt_val_d = 1'b1;
        filt_bit_d = filt_acc_q ^ src_bit;
        filt_cnt_d = '0;
        filt_acc_d = 1'b0;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
        filt_acc_d = filt_acc_q ^ src_bit;
      end
    end

    if (filt_val_q) begin
      asm_d = {asm_q[W-2:0], filt_bit_q};
      if (asm_cnt_q == CW'(W - 1)) begin
        asm_cnt_d   = '0;
        pend_d      = 1'b1;
        pend_word_d = {asm_q[W-2:0], filt_bit_q};
      end else begin
        asm_cnt_d = asm_cnt_q + CW'(1);
      end
    end

`ifdef TRNG_POOL_HEALTH_EN
    run_d  = run_q;
    last_d = last_q;
    if (accept) begin
      run_d  = (run_q != '0 && src_bit == last_q) ? run_q + 8'd1 : 8'd1;
      last_d = src_bit;
    end
    if (alarm_clr) begin
      alarm_d = 1'b0;
      run_d   = '0;
    end
    // A new failure overrides a coincident clear.
    if (run_q >= 8'(RCT_C)) begin
      alarm_d = 1'b1;
      run_d   = '0;
      flush   = 1'b1;
    end
`else
    alarm_d = 1'b0;
`endif

    if (flush) begin
      filt_cnt_d = '0;
      filt_acc_d = 1'b0;
      filt_val_d = 1'b0;
      asm_d      = '0;
      asm_cnt_d  = '0;
      pend_d     = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
    end

    src_en_d = (level_d < LW'(DEPTH)) && !alarm_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_cnt_q  <= '0;
      filt_acc_q  <= 1'b0;
      filt_val_q  <= 1'b0;
      filt_bit_q  <= 1'b0;
      asm_q       <= '0;
      asm_cnt_q   <= '0;
      pend_q      <= 1'b0;
      pend_word_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      src_en_q    <= 1'b0;
      alarm_q     <= 1'b0;
`ifdef TRNG_POOL_HEALTH_EN
      run_q       <= '0;
      last_q      <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      filt_cnt_q  <= filt_cnt_d;
      filt_acc_q  <= filt_acc_d;
      filt_val_q  <= filt_val_d;
      filt_bit_q  <= filt_bit_d;
      asm_q       <= asm_d;
      asm_cnt_q   <= asm_cnt_d;
      pend_q      <= pend_d;
      pend_word_q <= pend_word_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      src_en_q    <= src_en_d;
      alarm_q     <= alarm_d;
`ifdef TRNG_POOL_HEALTH_EN
      run_q       <= run_d;
      last_q      <= last_d;
`endif
    end
  end

  // NOTE: buffer storage has no reset; level and rd_val guard every stale entry.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= pend_word_q;
  end

  assign rdn    = mem[rd_ptr_q];
  assign level  = level_q;
  assign src_en = src_en_q;
  assign alarm  = alarm_q;

endmodule

// File: doc/trng_pool.md
TRNG_POOL -- requirements
Module: trng_pool

Interface
REQ-001 Parameter W, default 32, width in bits of each output random word; W >= 2.
REQ-002 Parameter ORD, default 3, parity post-filter order (raw bits folded per filtered bit); ORD >= 2.
REQ-003 Parameter DEPTH, default 4, number of W-bit words held in the output buffer; power of two, >= 2.
REQ-004 Parameter RCT_C, default 16, repetition-count cutoff on raw bits; 2 <= RCT_C <= 255.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 src_en  out  1  enable to the entropy source; high means raw bits are wanted.
REQ-008 src_val  in  1  raw bit strobe from the entropy source; src_bit is valid this cycle.
REQ-009 src_bit  in  1  raw entropy bit.
REQ-010 rd_req  in  1  consumer pop request.
REQ-011 rd_val  out  1  a word is available on rdn.
REQ-012 rdn  out  W  head-of-buffer random word; value is meaningful only while rd_val is high.
REQ-013 level  out  $clog2(DEPTH)+1  number of words currently buffered.
REQ-014 alarm  out  1  sticky health-test failure flag.
REQ-015 alarm_clr  in  1  clears alarm and restarts collection.

Function
REQ-016 src_en SHALL equal (level < DEPTH) and not alarm, and SHALL be registered.
REQ-017 Raw bits with src_val high SHALL be accepted only while src_en is high; others SHALL be ignored.
REQ-018 Every ORD accepted raw bits SHALL yield one filtered bit equal to the XOR of those ORD bits, valid the cycle after the ORD-th raw bit.
REQ-019 Filtered bits SHALL shift in at the LSB of a W-bit assembly register; the first filtered bit ends at the MSB.
REQ-020 When the W-th filtered bit is shifted in, the completed word SHALL be written to the buffer tail on the next cycle, and the bit counter SHALL wrap to 0.
REQ-021 The buffer SHALL be FIFO-ordered; rdn SHALL show the head word combinationally from buffer storage.
REQ-022 A pop SHALL occur when rd_req and rd_val are both high on a clock edge; level SHALL decrement on that edge.
REQ-023 rd_val SHALL equal (level != 0) and not alarm.
REQ-024 A simultaneous push and pop SHALL leave level unchanged and preserve order.
REQ-025 A push while level == DEPTH SHALL NOT occur; src_en gating ensures this, and in-flight bits then fill at most one pending word, which SHALL be held until space frees.
REQ-026 rd_req while rd_val is low SHALL have no effect.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-028 On rst: level=0, pointers=0, rd_val=0, src_en=0, alarm=0, filter and assembly counters=0, assembly register=0.
REQ-029 src_en SHALL rise on the first cycle after rst deasserts.
REQ-030 rst mid-word SHALL discard the partial word and all buffered words.

Configuration
REQ-031 Macro TRNG_POOL_HEALTH_EN compiles in the repetition-count health test.
REQ-032 With the macro defined: a counter SHALL track consecutive identical accepted raw bits. When the run reaches RCT_C, alarm SHALL set on the next edge. The buffer, partial word and filter state SHALL be flushed. alarm SHALL stay high until alarm_clr or rst.
REQ-033 alarm_clr SHALL clear alarm and the run counter on the next edge; if alarm_clr coincides with a new failure, the failure SHALL win.
REQ-034 Without the macro: alarm SHALL be tied 0, alarm_clr SHALL be ignored, and no run counter SHALL be synthesised.

Verification
REQ-035 W=8, ORD=3: feed raw bits 1,1,0 repeated 24 times -> rd_val rises with rdn=8'h00; pattern 1,0,0 x24 -> rdn=8'hFF.
REQ-036 DEPTH=4: never pop -> level reaches 4, src_en falls within 1 cycle, and level never exceeds 4; then pop once -> src_en rises.
REQ-037 Push and pop on the same edge with level=2 -> level stays 2, and the popped word is the oldest.
REQ-038 HEALTH_EN, RCT_C=16: 16 consecutive raw 0s -> alarm=1, level=0, rd_val=0, src_en=0; pulse alarm_clr -> alarm=0 and src_en=1 next cycle.
REQ-039 Assert rst after 5 filtered bits -> all outputs at reset values; the next word is built only from post-reset bits.
REQ-040 Toggle src_val while src_en=0 -> level and the assembly counter stay unchanged.
